// File: rtl/instruction_fetch_stage.sv
// ----------------------------------------------------------------------------
// instruction_fetch_stage
// Fetch stage of the 64-bit RISC-V pipeline. Holds the PC, issues one
// instruction request at a time, and loads the IF/ID register for decode.
// It obeys the decode stall enables and EX branch redirects, and it inserts
// bubbles when IF/ID advances without a new instruction.
//
// Parameters:
//   BUS_DATA_WIDTH  PC / address width (default 64)
//   RESET_PC        PC value loaded on reset
//
// Optional feature:
//   IFETCH_PERF_CNT_EN  when defined, adds outStallCount, a saturating count
//                       of stall cycles (inPCWrite=0 or inIfIdWrite=0).
//
// Ports:
//   clk, reset_n                     clock, async active-low reset
//   inPCWrite, inIfIdWrite           stall controls from hazard detection
//   inBranchTaken, inBranchTarget    redirect from EX
//   outReqValid/inReqReady/outReqAddr  instruction request handshake
//   inRespValid, inRespData          returned instruction word
//   outIfIdValid/outIfIdPC/outIfIdIns  IF/ID pipeline register
//   outStallCount                    stall counter (IFETCH_PERF_CNT_EN only)
// ----------------------------------------------------------------------------
module instruction_fetch_stage #(
   parameter int unsigned                BUS_DATA_WIDTH = 64,
   parameter logic [BUS_DATA_WIDTH-1:0]  RESET_PC       = '0
) (
   input  logic                      clk,
   input  logic                      reset_n,
   input  logic                      inPCWrite,
   input  logic                      inIfIdWrite,
   input  logic                      inBranchTaken,
   input  logic [BUS_DATA_WIDTH-1:0] inBranchTarget,
   output logic                      outReqValid,
   input  logic                      inReqReady,
   output logic [BUS_DATA_WIDTH-1:0] outReqAddr,
   input  logic                      inRespValid,
   input  logic [31:0]               inRespData,
   output logic                      outIfIdValid,
   output logic [BUS_DATA_WIDTH-1:0] outIfIdPC,
   output logic [31:0]               outIfIdIns
`ifdef IFETCH_PERF_CNT_EN
   ,
   output logic [31:0]               outStallCount
`endif
);

   localparam int unsigned INS_W = 32;
   localparam int unsigned CNT_W = 32;
   localparam logic [INS_W-1:0]          NOP_INS = INS_W'(32'h0000_0013);
   localparam logic [BUS_DATA_WIDTH-1:0] PC_STEP = BUS_DATA_WIDTH'(4);

   typedef enum logic [1:0] {
      ST_REQ  = 2'd0,
      ST_WAIT = 2'd1,
      ST_HOLD = 2'd2
   } state_e;

   state_e                    state_q, state_d;
   logic [BUS_DATA_WIDTH-1:0] pc_q, pc_d;
   logic [INS_W-1:0]          buf_q, buf_d;
   logic                      discard_q, discard_d;
   logic                      ifid_valid_q, ifid_valid_d;
   logic [BUS_DATA_WIDTH-1:0] ifid_pc_q, ifid_pc_d;
   logic [INS_W-1:0]          ifid_ins_q, ifid_ins_d;

   logic                      req_fire;
   logic                      advance;
   logic                      deliver;
   logic [INS_W-1:0]          deliver_ins;
   logic [BUS_DATA_WIDTH-1:0] target_aligned;
   logic                      unused_target_lsbs;

   assign req_fire           = (state_q == ST_REQ) && inReqReady;
   assign advance            = inPCWrite && inIfIdWrite;
   assign target_aligned     = {inBranchTarget[BUS_DATA_WIDTH-1:2], 2'b00};
   assign unused_target_lsbs = ^inBranchTarget[1:0];

   // Next-state, PC, buffer and IF/ID update
   always_comb begin
      state_d      = state_q;
      pc_d         = pc_q;
      buf_d        = buf_q;
      discard_d    = discard_q;
      ifid_valid_d = ifid_valid_q;
      ifid_pc_d    = ifid_pc_q;
      ifid_ins_d   = ifid_ins_q;
      deliver      = 1'b0;
      deliver_ins  = buf_q;

      if (inBranchTaken) begin
         // Redirect wins: new PC, bubble in IF/ID, any in-flight word goes stale
         pc_d         = target_aligned;
         ifid_valid_d = 1'b0;
         ifid_ins_d   = NOP_INS;
         case (state_q)
            ST_REQ: begin
               if (req_fire) begin
                  state_d   = ST_WAIT;
                  discard_d = 1'b1;
               end
            end
            ST_WAIT: begin
               if (inRespValid) begin
                  state_d   = ST_REQ;
                  discard_d = 1'b0;
               end else begin
                  discard_d = 1'b1;
               end
            end
            default: state_d = ST_REQ;
         endcase
      end else begin
         case (state_q)
            ST_REQ: begin
               if (req_fire) state_d = ST_WAIT;
            end
            ST_WAIT: begin
               if (inRespValid) begin
                  if (discard_q) begin
                     discard_d = 1'b0;
                     state_d   = ST_REQ;
                  end else if (advance) begin
                     deliver     = 1'b1;
                     deliver_ins = inRespData;
                     state_d     = ST_REQ;
                  end else begin
                     buf_d   = inRespData;
                     state_d = ST_HOLD;
                  end
               end
            end
            ST_HOLD: begin
               if (advance) begin
                  deliver = 1'b1;
                  state_d = ST_REQ;
               end
            end
            default: state_d = ST_REQ;
         endcase

         // PC only moves together with an IF/ID load
         if (deliver) begin
            ifid_valid_d = 1'b1;
            ifid_pc_d    = pc_q;
            ifid_ins_d   = deliver_ins;
            pc_d         = pc_q + PC_STEP;
         end else if (inIfIdWrite) begin
            ifid_valid_d = 1'b0;
            ifid_ins_d   = NOP_INS;
         end
      end
   end

   // State and pipeline registers
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= ST_REQ;
         pc_q         <= RESET_PC;
         buf_q        <= '0;
         discard_q    <= 1'b0;
         ifid_valid_q <= 1'b0;
         ifid_pc_q    <= '0;
         ifid_ins_q   <= NOP_INS;
      end else begin
         state_q      <= state_d;
         pc_q         <= pc_d;
         buf_q        <= buf_d;
         discard_q    <= discard_d;
         ifid_valid_q <= ifid_valid_d;
         ifid_pc_q    <= ifid_pc_d;
         ifid_ins_q   <= ifid_ins_d;
      end
   end

   // Gated by reset_n so the request is low in reset and up in the first cycle after
   assign outReqValid  = (state_q == ST_REQ) && reset_n;
   assign outReqAddr   = pc_q;
   assign outIfIdValid = ifid_valid_q;
   assign outIfIdPC    = ifid_pc_q;
   assign outIfIdIns   = ifid_ins_q;

`ifdef IFETCH_PERF_CNT_EN
   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

   // Saturating stall-cycle counter
   always_comb begin
      stall_cnt_d = stall_cnt_q;
      if ((!inPCWrite || !inIfIdWrite) && (stall_cnt_q != '1)) begin
         stall_cnt_d = stall_cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) stall_cnt_q <= '0;
      else          stall_cnt_q <= stall_cnt_d;
   end

   assign outStallCount = stall_cnt_q;
`endif

endmodule

// File: tb/tb_instruction_fetch_stage.sv
// ----------------------------------------------------------------------------
// tb_instruction_fetch_stage
// Drives instruction_fetch_stage with directed and randomized stall, redirect
// and memory-latency patterns. A transaction-level model (pending request,
// stale flag, buffered word, IF/ID contents) predicts every output each cycle.
// ----------------------------------------------------------------------------
module tb_instruction_fetch_stage;

   localparam logic [63:0] RST_PC = 64'h1000;
   localparam logic [31:0] NOP    = 32'h0000_0013;

   logic        clk;
   logic        reset_n;
   logic        inPCWrite, inIfIdWrite, inBranchTaken, inReqReady, inRespValid;
   logic [63:0] inBranchTarget;
   logic [31:0] inRespData;
   logic        outReqValid;
   logic [63:0] outReqAddr;
   logic        outIfIdValid;
   logic [63:0] outIfIdPC;
   logic [31:0] outIfIdIns;
`ifdef IFETCH_PERF_CNT_EN
   logic [31:0] outStallCount;
`endif

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model state
   bit          m_rst;
   logic [63:0] m_pc;
   bit          m_out, m_stale, m_hasbuf;
   logic [31:0] m_buf;
   bit          m_ifv;
   logic [63:0] m_ifpc;
   logic [31:0] m_ifins;
   logic [31:0] m_stall;

   // Instruction memory model: one pending request with a latency counter
   bit          mem_pend;
   logic [63:0] mem_addr;
   int          mem_delay;
   int          fixed_delay;

   instruction_fetch_stage #(
      .BUS_DATA_WIDTH(64),
      .RESET_PC      (RST_PC)
   ) dut (
      .clk           (clk),
      .reset_n       (reset_n),
      .inPCWrite     (inPCWrite),
      .inIfIdWrite   (inIfIdWrite),
      .inBranchTaken (inBranchTaken),
      .inBranchTarget(inBranchTarget),
      .outReqValid   (outReqValid),
      .inReqReady    (inReqReady),
      .outReqAddr    (outReqAddr),
      .inRespValid   (inRespValid),
      .inRespData    (inRespData),
      .outIfIdValid  (outIfIdValid),
      .outIfIdPC     (outIfIdPC),
      .outIfIdIns    (outIfIdIns)
`ifdef IFETCH_PERF_CNT_EN
      ,
      .outStallCount (outStallCount)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] mem_word(input logic [63:0] a);
      if (a == 64'h1000) return 32'h0050_0093;
      return a[31:0] ^ 32'hC0DE_0003;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_pc     = RST_PC;
      m_out    = 1'b0;
      m_stale  = 1'b0;
      m_hasbuf = 1'b0;
      m_buf    = '0;
      m_ifv    = 1'b0;
      m_ifpc   = '0;
      m_ifins  = NOP;
      m_stall  = '0;
      mem_pend = 1'b0;
      mem_addr = '0;
      mem_delay = 0;
   endtask

   task automatic check_outputs();
      chk("req_valid", outReqValid, 64'(!m_rst && !m_out && !m_hasbuf));
      chk("req_addr", outReqAddr, m_pc);
      chk("ifid_valid", outIfIdValid, 64'(m_ifv));
      chk("ifid_pc", outIfIdPC, m_ifpc);
      chk("ifid_ins", outIfIdIns, m_ifins);
`ifdef IFETCH_PERF_CNT_EN
      chk("stall_count", outStallCount, m_stall);
`endif
   endtask

   // One clock cycle: check outputs, drive inputs, advance the model, wait.
   task automatic step(input bit pcw, input bit ifw, input bit br,
                       input logic [63:0] tgt, input bit rdy);
      bit          rv, fire, adv, got, delivered;
      logic [31:0] rd, w;
      check_outputs();
      rv = mem_pend && (mem_delay == 0);
      rd = rv ? mem_word(mem_addr) : $urandom;
      inPCWrite      = pcw;
      inIfIdWrite    = ifw;
      inBranchTaken  = br;
      inBranchTarget = tgt;
      inReqReady     = rdy;
      inRespValid    = rv;
      inRespData     = rd;

      fire      = !m_out && !m_hasbuf && rdy;
      adv       = pcw && ifw;
      got       = 1'b0;
      delivered = 1'b0;
      w         = '0;
      if ((!pcw || !ifw) && (m_stall != 32'hFFFF_FFFF)) m_stall = m_stall + 1;

      if (rv) mem_pend = 1'b0;
      else if (mem_pend && mem_delay > 0) mem_delay--;
      if (fire) begin
         mem_pend  = 1'b1;
         mem_addr  = m_pc;
         mem_delay = (fixed_delay >= 0) ? fixed_delay : int'($urandom_range(0, 3));
      end

      if (br) begin
         if (fire) begin
            m_out   = 1'b1;
            m_stale = 1'b1;
         end else if (m_out) begin
            if (rv) begin
               m_out   = 1'b0;
               m_stale = 1'b0;
            end else begin
               m_stale = 1'b1;
            end
         end
         m_hasbuf = 1'b0;
         m_pc     = tgt & ~64'h3;
         m_ifv    = 1'b0;
         m_ifins  = NOP;
      end else begin
         if (m_out && rv) begin
            m_out = 1'b0;
            if (m_stale) m_stale = 1'b0;
            else begin
               got = 1'b1;
               w   = rd;
            end
         end else if (m_hasbuf) begin
            got = 1'b1;
            w   = m_buf;
         end
         if (got) begin
            if (adv) begin
               m_ifv     = 1'b1;
               m_ifpc    = m_pc;
               m_ifins   = w;
               m_pc      = m_pc + 64'd4;
               m_hasbuf  = 1'b0;
               delivered = 1'b1;
            end else begin
               m_hasbuf = 1'b1;
               m_buf    = w;
            end
         end
         if (fire) m_out = 1'b1;
         if (!delivered && ifw) begin
            m_ifv   = 1'b0;
            m_ifins = NOP;
         end
      end
      @(negedge clk);
   endtask

   task automatic rand_step();
      bit          pcw, ifw, br, rdy;
      logic [63:0] tgt;
      pcw = ($urandom_range(0, 3) != 0);
      ifw = ($urandom_range(0, 3) != 0);
      br  = ($urandom_range(0, 15) == 0);
      rdy = ($urandom_range(0, 3) != 0);
      tgt = {$urandom, $urandom};
      step(pcw, ifw, br, tgt, rdy);
   endtask

   task automatic check_reset_values();
      chk("rst_req_valid", outReqValid, 64'd0);
      chk("rst_req_addr", outReqAddr, 64'h1000);
      chk("rst_ifid_valid", outIfIdValid, 64'd0);
      chk("rst_ifid_pc", outIfIdPC, 64'd0);
      chk("rst_ifid_ins", outIfIdIns, 64'h13);
`ifdef IFETCH_PERF_CNT_EN
      chk("rst_stall_count", outStallCount, 64'd0);
`endif
   endtask

   initial begin
      reset_n        = 1'b0;
      inPCWrite      = 1'b1;
      inIfIdWrite    = 1'b1;
      inBranchTaken  = 1'b0;
      inBranchTarget = '0;
      inReqReady     = 1'b0;
      inRespValid    = 1'b0;
      inRespData     = '0;
      fixed_delay    = 0;
      model_reset();
      m_rst = 1'b1;
      repeat (3) @(negedge clk);
      check_reset_values();
      reset_n = 1'b1;
      #1;
      m_rst = 1'b0;

      // First fetch: request at RESET_PC, response one cycle after handshake
      chk("first_req_valid", outReqValid, 64'd1);
      chk("first_req_addr", outReqAddr, 64'h1000);
      step(1, 1, 0, '0, 1);
      step(1, 1, 0, '0, 1);
      chk("fetch0_ifid_valid", outIfIdValid, 64'd1);
      chk("fetch0_ifid_pc", outIfIdPC, 64'h1000);
      chk("fetch0_ifid_ins", outIfIdIns, 64'h0050_0093);
      chk("fetch0_next_addr", outReqAddr, 64'h1004);

      // Memory not ready for 3 cycles: address held
      for (int i = 0; i < 3; i++) begin
         step(1, 1, 0, '0, 0);
         chk("rdy_stall_valid", outReqValid, 64'd1);
         chk("rdy_stall_addr", outReqAddr, 64'h1004);
      end

      // Response lands during a 2-cycle stall: word buffered, IF/ID held
      step(1, 1, 0, '0, 1);
      step(0, 0, 0, '0, 1);
      step(0, 0, 0, '0, 1);
      chk("hold_req_valid", outReqValid, 64'd0);
      chk("hold_ifid_valid", outIfIdValid, 64'd0);
      chk("hold_ifid_pc", outIfIdPC, 64'h1000);
      chk("hold_ifid_ins", outIfIdIns, 64'h13);
      chk("hold_addr", outReqAddr, 64'h1004);
`ifdef IFETCH_PERF_CNT_EN
      chk("hold_stall_count", outStallCount, 64'd2);
`endif
      step(1, 1, 0, '0, 1);
      chk("release_ifid_valid", outIfIdValid, 64'd1);
      chk("release_ifid_pc", outIfIdPC, 64'h1004);
      chk("release_ifid_ins", outIfIdIns, 64'(mem_word(64'h1004)));
      chk("release_next_addr", outReqAddr, 64'h1008);

      // Redirect while waiting: bubble, stale word dropped, aligned target
      fixed_delay = 1;
      step(1, 1, 0, '0, 1);
      step(1, 1, 1, 64'h2002, 0);
      chk("br_ifid_valid", outIfIdValid, 64'd0);
      chk("br_ifid_ins", outIfIdIns, 64'h13);
      chk("br_wait_valid", outReqValid, 64'd0);
      step(1, 1, 0, '0, 0);
      chk("br_req_valid", outReqValid, 64'd1);
      chk("br_req_addr", outReqAddr, 64'h2000);
      chk("br_drop_ifid_valid", outIfIdValid, 64'd0);

      // PC wrap-around
      fixed_delay = 0;
      step(1, 1, 1, 64'hFFFF_FFFF_FFFF_FFFC, 0);
      chk("wrap_req_addr", outReqAddr, 64'hFFFF_FFFF_FFFF_FFFC);
      step(1, 1, 0, '0, 1);
      step(1, 1, 0, '0, 0);
      chk("wrap_ifid_valid", outIfIdValid, 64'd1);
      chk("wrap_ifid_pc", outIfIdPC, 64'hFFFF_FFFF_FFFF_FFFC);
      chk("wrap_next_addr", outReqAddr, 64'h0);

      // Randomized traffic
      fixed_delay = -1;
      for (int i = 0; i < 3000; i++) rand_step();

      // Reset while a request is outstanding
      fixed_delay = 3;
      begin
         int budget;
         budget = 0;
         while (!m_out && budget < 50) begin
            step(1, 1, 0, '0, 1);
            budget++;
         end
         if (!m_out) begin
            n_checks++;
            n_fail++;
            $display("FAIL reach_wait: no outstanding request within %0d cycles", budget);
         end
      end
      reset_n = 1'b0;
      #1;
      check_reset_values();
      model_reset();
      m_rst = 1'b1;
      @(negedge clk);
      reset_n = 1'b1;
      #1;
      m_rst = 1'b0;
      chk("post_rst_req_valid", outReqValid, 64'd1);
      chk("post_rst_req_addr", outReqAddr, 64'h1000);

      fixed_delay = -1;
      for (int i = 0; i < 500; i++) rand_step();
      check_outputs();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
